// File: rtl/rtc_timekeeper.sv
// Real-time clock: prescales i_clk to a 1 Hz tick and keeps secs/mins/hours with load, run gating and strobes.
// Optional alarm (inputs i_alarmSet/i_al*/i_alarmClr, outputs o_alarmHit/o_alarmPend) is enabled by defining RTC_ALARM_EN.
module rtc_timekeeper #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int HOURS_W   = 16,
  parameter int HOURS_MAX = 0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_run,
  input  logic               i_load,
  input  logic [7:0]         i_ldSecs,
  input  logic [7:0]         i_ldMins,
  input  logic [HOURS_W-1:0] i_ldHours,
`ifdef RTC_ALARM_EN
  input  logic               i_alarmSet,
  input  logic [7:0]         i_alSecs,
  input  logic [7:0]         i_alMins,
  input  logic [HOURS_W-1:0] i_alHours,
  input  logic               i_alarmClr,
  output logic               o_alarmHit,
  output logic               o_alarmPend,
`endif
  output logic [7:0]         o_secs,
  output logic [7:0]         o_mins,
  output logic [HOURS_W-1:0] o_hours,
  output logic               o_tick,
  output logic               o_dayWrap,
  output logic               o_loadErr
);

  localparam int PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0]      PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [HOURS_W-1:0] HOUR_LAST  = (HOURS_MAX == 0) ? {HOURS_W{1'b1}} : HOURS_W'(HOURS_MAX - 1);
  localparam logic [HOURS_W:0]   HOUR_LIM   = (HOURS_W + 1)'(HOURS_MAX);

  logic [PW-1:0]      r_presc;
  logic [7:0]         r_secs;
  logic [7:0]         r_mins;
  logic [HOURS_W-1:0] r_hours;
  logic               r_tick;
  logic               r_dayWrap;
  logic               r_loadErr;

  logic [7:0]         w_nSecs;
  logic [7:0]         w_nMins;
  logic [HOURS_W-1:0] w_nHours;
  logic               w_dayWrapNow;
  logic               w_ldOk;
  logic               w_loadOk;
  logic               w_tickNow;
  logic               w_advance;
  logic               w_errNow;

  assign w_ldOk    = (i_ldSecs < 8'd60) && (i_ldMins < 8'd60) &&
                     ((HOURS_MAX == 0) || ({1'b0, i_ldHours} < HOUR_LIM));
  assign w_loadOk  = i_load && w_ldOk;
  assign w_tickNow = i_run && (r_presc == PRESC_LAST);
  assign w_advance = w_tickNow && !w_loadOk;

  // Full ripple of the carry chain in a single cycle; the hour limit is a constant compare.
  always_comb begin
    w_nSecs      = r_secs + 8'd1;
    w_nMins      = r_mins;
    w_nHours     = r_hours;
    w_dayWrapNow = 1'b0;
    if (r_secs == 8'd59) begin
      w_nSecs = 8'd0;
      w_nMins = r_mins + 8'd1;
      if (r_mins == 8'd59) begin
        w_nMins = 8'd0;
        if (r_hours == HOUR_LAST) begin
          w_nHours     = '0;
          w_dayWrapNow = 1'b1;
        end else begin
          w_nHours = r_hours + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_presc   <= '0;
      r_secs    <= 8'd0;
      r_mins    <= 8'd0;
      r_hours   <= '0;
      r_tick    <= 1'b0;
      r_dayWrap <= 1'b0;
      r_loadErr <= 1'b0;
    end else begin
      r_tick    <= 1'b0;
      r_dayWrap <= 1'b0;
      r_loadErr <= w_errNow;
      if (w_loadOk) begin
        r_presc <= '0;
        r_secs  <= i_ldSecs;
        r_mins  <= i_ldMins;
        r_hours <= i_ldHours;
      end else if (i_run) begin
        r_presc <= w_tickNow ? '0 : r_presc + 1'b1;
        if (w_tickNow) begin
          r_secs    <= w_nSecs;
          r_mins    <= w_nMins;
          r_hours   <= w_nHours;
          r_tick    <= 1'b1;
          r_dayWrap <= w_dayWrapNow;
        end
      end
    end
  end

`ifdef RTC_ALARM_EN
  logic [7:0]         r_alSecs;
  logic [7:0]         r_alMins;
  logic [HOURS_W-1:0] r_alHours;
  logic               r_armed;
  logic               r_alarmHit;
  logic               r_alarmPend;
  logic               w_alOk;
  logic               w_fire;

  assign w_alOk   = (i_alSecs < 8'd60) && (i_alMins < 8'd60) &&
                    ((HOURS_MAX == 0) || ({1'b0, i_alHours} < HOUR_LIM));
  assign w_errNow = (i_load && !w_ldOk) || (i_alarmSet && !w_alOk);
  // Only a real tick advance can fire; loading onto the alarm time does not.
  assign w_fire   = w_advance && r_armed && (w_nSecs == r_alSecs) &&
                    (w_nMins == r_alMins) && (w_nHours == r_alHours);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_alSecs    <= 8'd0;
      r_alMins    <= 8'd0;
      r_alHours   <= '0;
      r_armed     <= 1'b0;
      r_alarmHit  <= 1'b0;
      r_alarmPend <= 1'b0;
    end else begin
      r_alarmHit <= w_fire;
      if (w_fire) begin
        r_armed     <= 1'b0;
        r_alarmPend <= 1'b1;
      end else if (i_alarmClr) begin
        r_alarmPend <= 1'b0;
      end
      if (i_alarmSet && w_alOk) begin
        r_alSecs  <= i_alSecs;
        r_alMins  <= i_alMins;
        r_alHours <= i_alHours;
        r_armed   <= 1'b1;
      end
    end
  end

  assign o_alarmHit  = r_alarmHit;
  assign o_alarmPend = r_alarmPend;
`else
  assign w_errNow = i_load && !w_ldOk;
`endif

  assign o_secs    = r_secs;
  assign o_mins    = r_mins;
  assign o_hours   = r_hours;
  assign o_tick    = r_tick;
  assign o_dayWrap = r_dayWrap;
  assign o_loadErr = r_loadErr;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Directed bench for rtc_timekeeper: a day clock (HOURS_MAX=24) and a free-running 4-bit-hours instance, CLK_HZ=10.
// Alarm checks are compiled in when RTC_ALARM_EN is defined.
module tb_rtc_timekeeper;

  logic        clk;
  logic        rst;
  logic        run;
  logic        load;
  logic [7:0]  ldSecs;
  logic [7:0]  ldMins;
  logic [15:0] ldHours;
  logic [7:0]  secs;
  logic [7:0]  mins;
  logic [15:0] hours;
  logic        tick;
  logic        dayWrap;
  logic        loadErr;

  logic        loadF;
  logic [7:0]  ldSecsF;
  logic [7:0]  ldMinsF;
  logic [3:0]  ldHoursF;
  logic [7:0]  fSecs;
  logic [7:0]  fMins;
  logic [3:0]  fHours;
  logic        fTick;
  logic        fDayWrap;
  logic        fLoadErr;

`ifdef RTC_ALARM_EN
  logic        alarmSet;
  logic [7:0]  alSecs;
  logic [7:0]  alMins;
  logic [15:0] alHours;
  logic        alarmClr;
  logic        alarmHit;
  logic        alarmPend;
  logic        fAlarmHit;
  logic        fAlarmPend;
`endif

  int compared   = 0;
  int mismatched = 0;

  rtc_timekeeper #(.CLK_HZ(10), .HOURS_W(16), .HOURS_MAX(24)) dut (
    .i_clk(clk), .i_rst(rst), .i_run(run), .i_load(load),
    .i_ldSecs(ldSecs), .i_ldMins(ldMins), .i_ldHours(ldHours),
`ifdef RTC_ALARM_EN
    .i_alarmSet(alarmSet), .i_alSecs(alSecs), .i_alMins(alMins), .i_alHours(alHours),
    .i_alarmClr(alarmClr), .o_alarmHit(alarmHit), .o_alarmPend(alarmPend),
`endif
    .o_secs(secs), .o_mins(mins), .o_hours(hours),
    .o_tick(tick), .o_dayWrap(dayWrap), .o_loadErr(loadErr)
  );

  rtc_timekeeper #(.CLK_HZ(10), .HOURS_W(4), .HOURS_MAX(0)) dutFree (
    .i_clk(clk), .i_rst(rst), .i_run(run), .i_load(loadF),
    .i_ldSecs(ldSecsF), .i_ldMins(ldMinsF), .i_ldHours(ldHoursF),
`ifdef RTC_ALARM_EN
    .i_alarmSet(1'b0), .i_alSecs(8'd0), .i_alMins(8'd0), .i_alHours(4'd0),
    .i_alarmClr(1'b0), .o_alarmHit(fAlarmHit), .o_alarmPend(fAlarmPend),
`endif
    .o_secs(fSecs), .o_mins(fMins), .o_hours(fHours),
    .o_tick(fTick), .o_dayWrap(fDayWrap), .o_loadErr(fLoadErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic countTicks(input int n, output int ticks);
    ticks = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tick) ticks++;
    end
  endtask

  task automatic checkTime(input string tag, input int h, input int m, input int s);
    checkOutput({tag, ".hours"}, 32'(hours), 32'(h));
    checkOutput({tag, ".mins"},  32'(mins),  32'(m));
    checkOutput({tag, ".secs"},  32'(secs),  32'(s));
  endtask

  // Drives a one-cycle load strobe into the day-clock instance.
  task automatic applyStimulus(input int h, input int m, input int s);
    ldHours = 16'(h);
    ldMins  = 8'(m);
    ldSecs  = 8'(s);
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
  endtask

`ifdef RTC_ALARM_EN
  task automatic countHits(input int n, output int hits);
    hits = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (alarmHit) hits++;
    end
  endtask
`endif

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; run = 1'b0; load = 1'b0; ldSecs = 8'd0; ldMins = 8'd0; ldHours = 16'd0;
    loadF = 1'b0; ldSecsF = 8'd0; ldMinsF = 8'd0; ldHoursF = 4'd0;
`ifdef RTC_ALARM_EN
    alarmSet = 1'b0; alSecs = 8'd0; alMins = 8'd0; alHours = 16'd0; alarmClr = 1'b0;
`endif
    stepCycles(3);
    checkTime("reset", 0, 0, 0);
    checkOutput("reset.tick", 32'(tick), 0);
    checkOutput("reset.dayWrap", 32'(dayWrap), 0);
    checkOutput("reset.loadErr", 32'(loadErr), 0);
    checkOutput("reset.freeHours", 32'(fHours), 0);

    $display("[TB] first tick and 600-cycle run");
    rst = 1'b0; run = 1'b1;
    stepCycles(9);
    checkOutput("preTick.tick", 32'(tick), 0);
    checkOutput("preTick.secs", 32'(secs), 0);
    stepCycles(1);
    checkOutput("firstTick.tick", 32'(tick), 1);
    checkOutput("firstTick.secs", 32'(secs), 1);
    countTicks(590, n);
    checkOutput("run600.ticks", 32'(n), 59);
    checkTime("run600", 0, 1, 0);

    $display("[TB] day wrap on both instances");
    ldSecsF = 8'd59; ldMinsF = 8'd59; ldHoursF = 4'd15; loadF = 1'b1;
    applyStimulus(23, 59, 58);
    loadF = 1'b0;
    checkTime("load235958", 23, 59, 58);
    checkOutput("load235958.tick", 32'(tick), 0);
    checkOutput("freeLoad.hours", 32'(fHours), 15);
    stepCycles(9);
    checkOutput("hold58.secs", 32'(secs), 58);
    stepCycles(1);
    checkTime("at235959", 23, 59, 59);
    checkOutput("at235959.tick", 32'(tick), 1);
    checkOutput("at235959.dayWrap", 32'(dayWrap), 0);
    checkOutput("freeWrap.hours", 32'(fHours), 0);
    checkOutput("freeWrap.mins", 32'(fMins), 0);
    checkOutput("freeWrap.secs", 32'(fSecs), 0);
    checkOutput("freeWrap.dayWrap", 32'(fDayWrap), 1);
    stepCycles(9);
    checkOutput("freeWrapEnd.dayWrap", 32'(fDayWrap), 0);
    stepCycles(1);
    checkTime("dayWrap", 0, 0, 0);
    checkOutput("dayWrap.tick", 32'(tick), 1);
    checkOutput("dayWrap.flag", 32'(dayWrap), 1);
    stepCycles(1);
    checkOutput("dayWrapEnd.flag", 32'(dayWrap), 0);

    $display("[TB] rejected loads and load on the wrap cycle");
    applyStimulus(1, 2, 60);
    checkOutput("badSecs.loadErr", 32'(loadErr), 1);
    checkTime("badSecs", 0, 0, 0);
    stepCycles(1);
    checkOutput("badSecsEnd.loadErr", 32'(loadErr), 0);
    applyStimulus(24, 0, 0);
    checkOutput("badHours.loadErr", 32'(loadErr), 1);
    checkOutput("badHours.hours", 32'(hours), 0);
    countTicks(5, n);
    checkOutput("badLoadKeepsPresc.ticks", 32'(n), 0);
    stepCycles(1);
    checkOutput("badLoadKeepsPresc.tick", 32'(tick), 1);
    checkOutput("badLoadKeepsPresc.secs", 32'(secs), 1);
    stepCycles(9);
    applyStimulus(1, 2, 3);
    checkTime("loadAtWrap", 1, 2, 3);
    checkOutput("loadAtWrap.tick", 32'(tick), 0);
    countTicks(9, n);
    checkOutput("afterLoad.ticks", 32'(n), 0);
    stepCycles(1);
    checkOutput("afterLoad.tick", 32'(tick), 1);
    checkOutput("afterLoad.secs", 32'(secs), 4);

    $display("[TB] run gating and mid-count reset");
    stepCycles(3);
    run = 1'b0;
    countTicks(25, n);
    checkOutput("paused.ticks", 32'(n), 0);
    checkTime("paused", 1, 2, 4);
    run = 1'b1;
    countTicks(6, n);
    checkOutput("resume.ticks", 32'(n), 0);
    stepCycles(1);
    checkOutput("resume.tick", 32'(tick), 1);
    checkOutput("resume.secs", 32'(secs), 5);
    stepCycles(5);
    rst = 1'b1;
    stepCycles(1);
    checkTime("midReset", 0, 0, 0);
    checkOutput("midReset.tick", 32'(tick), 0);
    rst = 1'b0;
    countTicks(9, n);
    checkOutput("postReset.ticks", 32'(n), 0);
    stepCycles(1);
    checkOutput("postReset.tick", 32'(tick), 1);
    checkOutput("postReset.secs", 32'(secs), 1);

`ifdef RTC_ALARM_EN
    $display("[TB] alarm");
    rst = 1'b1;
    stepCycles(1);
    checkOutput("alarmReset.pend", 32'(alarmPend), 0);
    rst = 1'b0;
    alarmSet = 1'b1; alHours = 16'd0; alMins = 8'd0; alSecs = 8'd5;
    stepCycles(1);
    alarmSet = 1'b0;
    countHits(48, n);
    checkOutput("alarmEarly.hits", 32'(n), 0);
    stepCycles(1);
    checkOutput("alarmFire.hit", 32'(alarmHit), 1);
    checkOutput("alarmFire.pend", 32'(alarmPend), 1);
    checkOutput("alarmFire.secs", 32'(secs), 5);
    stepCycles(1);
    checkOutput("alarmAfter.hit", 32'(alarmHit), 0);
    checkOutput("alarmAfter.pend", 32'(alarmPend), 1);
    applyStimulus(0, 0, 0);
    countHits(60, n);
    checkOutput("oneShot.hits", 32'(n), 0);
    checkOutput("oneShot.pend", 32'(alarmPend), 1);
    alarmClr = 1'b1;
    stepCycles(1);
    alarmClr = 1'b0;
    checkOutput("alarmClr.pend", 32'(alarmPend), 0);
    alarmSet = 1'b1; alMins = 8'd0; alSecs = 8'd9;
    stepCycles(1);
    alMins = 8'd60;
    stepCycles(1);
    alarmSet = 1'b0;
    checkOutput("badAlarm.loadErr", 32'(loadErr), 1);
    applyStimulus(0, 0, 9);
    checkOutput("loadOnAlarm.hit", 32'(alarmHit), 0);
    checkOutput("loadOnAlarm.secs", 32'(secs), 9);
    applyStimulus(0, 0, 8);
    countHits(9, n);
    checkOutput("keptAlarm.early", 32'(n), 0);
    alarmClr = 1'b1;
    stepCycles(1);
    checkOutput("keptAlarm.hit", 32'(alarmHit), 1);
    checkOutput("setBeatsClr.pend", 32'(alarmPend), 1);
    stepCycles(1);
    alarmClr = 1'b0;
    checkOutput("clrAfterHit.pend", 32'(alarmPend), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
